// File: rtl/decimal_entry_pkg.sv
// Shared types and constants for the decimal entry path: FSM states, BCD digit type and
// the reverse double-dabble correction constants.
package decimal_entry_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t  BCD_MAX_DIGIT    = 4'd9;
  localparam int unsigned SHIFT_COUNT      = 8;
  localparam bcd_digit_t  DABBLE_THRESHOLD = 4'd8;
  localparam bcd_digit_t  DABBLE_CORR      = 4'd3;

  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
    return (d == BCD_MAX_DIGIT) ? 4'd0 : d + 4'd1;
  endfunction

  // Undo the +3 that forward double-dabble would have applied to this nibble.
  function automatic bcd_digit_t dabble(input bcd_digit_t d);
    return (d >= DABBLE_THRESHOLD) ? d - DABBLE_CORR : d;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Asynchronous button synchronizer followed by a rising-edge detector that yields a
// single-cycle pulse per press, however long the button is held.
module btn_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2  // must be at least 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/decimal_entry_loader.sv
// Two-digit BCD entry stepped by push-buttons, converted to saturated binary by a
// sequential reverse double-dabble and handed out with a one-cycle valid pulse.
module decimal_entry_loader
  import decimal_entry_pkg::*;
#(
  parameter int unsigned N           = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_unit,
  input  logic         btn_ten,
  input  logic         btn_load,
  output logic [7:0]   bcd_out,
  output logic [N-1:0] data_out,
  output logic         load_valid,
  output logic         overflow,
  output logic         busy
);

  localparam logic [31:0] MaxValue  = 32'((64'd1 << N) - 64'd1);
  localparam logic [3:0]  LastShift = 4'(SHIFT_COUNT - 1);

  logic unit_pulse, ten_pulse, load_pulse;

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_unit (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_unit),
    .pulse(unit_pulse)
  );

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ten (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_ten),
    .pulse(ten_pulse)
  );

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_load),
    .pulse(load_pulse)
  );

  state_e       state_q, state_d;
  bcd_digit_t   tens_q, tens_d;
  bcd_digit_t   units_q, units_d;
  logic [7:0]   bcd_work_q, bcd_work_d;
  logic [7:0]   bin_work_q, bin_work_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N-1:0] data_q, data_d;
  logic         ovf_q, ovf_d;
  logic         valid_q, valid_d;
  logic [15:0]  shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tens_q     <= '0;
      units_q    <= '0;
      bcd_work_q <= '0;
      bin_work_q <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      bcd_work_q <= bcd_work_d;
      bin_work_q <= bin_work_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    units_d    = units_q;
    bcd_work_d = bcd_work_q;
    bin_work_d = bin_work_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    shifted    = {bcd_work_q, bin_work_q} >> 1;

    unique case (state_q)
      StIdle: begin
        // A load in the same cycle as a digit press captures the pre-increment entry.
        if (load_pulse) begin
          bcd_work_d = {tens_q, units_q};
          bin_work_d = '0;
          cnt_d      = '0;
          state_d    = StShift;
        end else begin
          if (unit_pulse) units_d = bcd_inc(units_q);
          if (ten_pulse)  tens_d  = bcd_inc(tens_q);
        end
      end
      StShift: begin
        bin_work_d = shifted[7:0];
        bcd_work_d = {dabble(shifted[15:12]), dabble(shifted[11:8])};
        cnt_d      = cnt_q + 4'd1;
        if (cnt_q == LastShift) state_d = StDone;
      end
      StDone: begin
        if (32'(bin_work_q) > MaxValue) begin
          data_d = '1;
          ovf_d  = 1'b1;
        end else begin
          data_d = N'(bin_work_q);
          ovf_d  = 1'b0;
        end
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bcd_out    = {tens_q, units_q};
  assign data_out   = data_q;
  assign load_valid = valid_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_decimal_entry_loader.sv
// Self-checking bench for decimal_entry_loader: button entry, conversion results via a
// scoreboard queue, timing corners, busy lockout and reset during conversion.
module tb_decimal_entry_loader;

  localparam int unsigned N = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_unit, btn_ten, btn_load;
  logic [7:0]   bcd_out;
  logic [N-1:0] data_out;
  logic         load_valid, overflow, busy;

  decimal_entry_loader #(.N(N), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_unit  (btn_unit),
    .btn_ten   (btn_ten),
    .btn_load  (btn_load),
    .bcd_out   (bcd_out),
    .data_out  (data_out),
    .load_valid(load_valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] data;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [3:0]   t;
    logic [3:0]   u;
    logic [N-1:0] data;
    logic         ovf;
  } vec_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   valid_count = 0;
  bit   last_valid = 1'b0;
  exp_t exp_q[$];
  logic [3:0] ent_t = 4'd0;
  logic [3:0] ent_u = 4'd0;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Output monitor: every load_valid pulse is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_valid = 1'b0;
      end else begin
        if (load_valid) begin
          valid_count++;
          if (last_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_valid_consecutive: got 2 cycles high, expected 1");
          end
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_load_valid: got pulse, expected none");
          end else begin
            e = exp_q.pop_front();
            check("data_out", 32'(data_out), 32'(e.data));
            check("overflow", 32'(overflow), 32'(e.ovf));
          end
        end
        last_valid = load_valid;
      end
    end
  end

  task automatic press_unit();
    btn_unit = 1'b1; tick(3);
    btn_unit = 1'b0; tick(3);
    ent_u = (ent_u == 4'd9) ? 4'd0 : 4'(ent_u + 4'd1);
  endtask

  task automatic press_ten();
    btn_ten = 1'b1; tick(3);
    btn_ten = 1'b0; tick(3);
    ent_t = (ent_t == 4'd9) ? 4'd0 : 4'(ent_t + 4'd1);
  endtask

  task automatic set_entry(input logic [3:0] t, input logic [3:0] u);
    while (ent_t != t) press_ten();
    while (ent_u != u) press_unit();
    check("bcd_out_entry", 32'(bcd_out), 32'({ent_t, ent_u}));
  endtask

  task automatic wait_valid(input int target);
    for (int i = 0; i < 40; i++) begin
      if (valid_count >= target) break;
      tick(1);
    end
    check("load_valid_count", 32'(valid_count), 32'(target));
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] u,
                         input logic [N-1:0] d, input logic o);
    int target;
    set_entry(t, u);
    target = valid_count + 1;
    exp_q.push_back('{data: d, ovf: o});
    btn_load = 1'b1; tick(3);
    btn_load = 1'b0;
    wait_valid(target);
    tick(2);
  endtask

  initial begin
    int lat;
    int target;
    int v;

    vecs[0] = '{t: 4'd6, u: 4'd4, data: 6'd63, ovf: 1'b1};
    vecs[1] = '{t: 4'd6, u: 4'd3, data: 6'd63, ovf: 1'b0};
    vecs[2] = '{t: 4'd0, u: 4'd0, data: 6'd0,  ovf: 1'b0};
    vecs[3] = '{t: 4'd9, u: 4'd9, data: 6'd63, ovf: 1'b1};
    vecs[4] = '{t: 4'd0, u: 4'd9, data: 6'd9,  ovf: 1'b0};
    vecs[5] = '{t: 4'd3, u: 4'd8, data: 6'd38, ovf: 1'b0};

    rst = 1'b1; btn_unit = 1'b0; btn_ten = 1'b0; btn_load = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset_bcd_out", 32'(bcd_out), 32'h00);
    check("reset_data_out", 32'(data_out), 0);
    check("reset_load_valid", 32'(load_valid), 0);
    check("reset_overflow", 32'(overflow), 0);
    check("reset_busy", 32'(busy), 0);

    // Units wrap without carry; tens wrap back to their start value.
    repeat (12) press_unit();
    check("units_x12", 32'(bcd_out), 32'h02);
    repeat (10) press_ten();
    check("tens_x10", 32'(bcd_out), 32'h02);

    btn_unit = 1'b1; tick(50);
    btn_unit = 1'b0; tick(4);
    ent_u = 4'd3;
    check("held_unit_once", 32'(bcd_out), 32'h03);

    // 0x47: latency from button drive = 2 sync stages + 10 cycles.
    set_entry(4'd4, 4'd7);
    check("bcd_out_47", 32'(bcd_out), 32'h47);
    target = valid_count + 1;
    exp_q.push_back('{data: 6'd47, ovf: 1'b0});
    btn_load = 1'b1;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (i == 2) check("busy_before_capture", 32'(busy), 0);
      if (i == 3) begin
        check("busy_after_capture", 32'(busy), 1);
        btn_load = 1'b0;
      end
      if (load_valid) begin
        lat = i;
        break;
      end
    end
    check("load_latency", 32'(lat), 12);
    wait_valid(target);
    tick(2);

    for (int k = 0; k < 6; k++) do_load(vecs[k].t, vecs[k].u, vecs[k].data, vecs[k].ovf);

    // Presses while busy are dropped, including a second load.
    set_entry(4'd2, 4'd5);
    target = valid_count + 1;
    exp_q.push_back('{data: 6'd25, ovf: 1'b0});
    btn_load = 1'b1; tick(3);
    btn_load = 1'b0; tick(1);
    check("busy_during_conv", 32'(busy), 1);
    btn_unit = 1'b1; btn_ten = 1'b1; btn_load = 1'b1; tick(3);
    btn_unit = 1'b0; btn_ten = 1'b0; btn_load = 1'b0;
    wait_valid(target);
    tick(15);
    check("busy_ignore_bcd", 32'(bcd_out), 32'h25);
    check("busy_ignore_no_second_valid", 32'(valid_count), 32'(target));

    // Load and unit in the same cycle: load wins and the increment is lost.
    set_entry(4'd1, 4'd9);
    target = valid_count + 1;
    exp_q.push_back('{data: 6'd19, ovf: 1'b0});
    btn_load = 1'b1; btn_unit = 1'b1; tick(3);
    btn_load = 1'b0; btn_unit = 1'b0;
    wait_valid(target);
    tick(4);
    check("same_cycle_units", 32'(bcd_out), 32'h19);

    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        v = t * 10 + u;
        do_load(4'(t), 4'(u), (v > 63) ? 6'd63 : 6'(v), v > 63);
      end
    end

    // Reset mid-conversion discards the result; last result was 99 -> saturated.
    target = valid_count;
    btn_load = 1'b1; tick(3);
    btn_load = 1'b0; tick(2);
    check("busy_before_reset", 32'(busy), 1);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    ent_t = 4'd0; ent_u = 4'd0;
    check("midreset_busy", 32'(busy), 0);
    check("midreset_bcd_out", 32'(bcd_out), 32'h00);
    check("midreset_data_out", 32'(data_out), 0);
    check("midreset_overflow", 32'(overflow), 0);
    tick(20);
    check("midreset_no_valid", 32'(valid_count), 32'(target));
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
